// File: rtl/ins_loader.sv
// Boot loader for the single-cycle MIPS core. It packs a big-endian byte stream into
// 32-bit words, writes them to instruction memory, and then releases the core from reset.
//
// state   | meaning
// IDLE    | after reset, core held, waiting for start
// COLLECT | accepting bytes of the current word
// WRITE   | one-cycle instruction memory write of the assembled word
// HOLD    | core still held for HOLD_CYC cycles after the last write
// RUN     | core released; a new start reloads the program
module ins_loader #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [5:0]        word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              InsWrEN,
  output logic [ADDR_W-1:0] InsWrAddr,
  output logic [31:0]       InsDataIn,
  output logic              cpu_nRST,
  output logic              cpu_nclear,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_HOLD    = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  state_t              state_q;
  logic [1:0]          byte_cnt_q;
  logic [CNT_W-1:0]    remaining_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [31:0]         asm_q;

  logic                byte_ready_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [31:0]         wr_data_q;
  logic                cpu_nrst_q;
  logic                cpu_nclear_q;
  logic                busy_q;
  logic                done_q;

  logic [CNT_W-1:0]    n_d;
  logic [31:0]         asm_d;

  // Requests larger than the memory are clamped so the address can never wrap.
  always_comb begin
    n_d = CNT_W'(word_count);
    if (int'(word_count) > DEPTH) begin
      n_d = CNT_W'(DEPTH);
    end
  end

  always_comb begin
    asm_d = asm_q;
    case (byte_cnt_q)
      2'd0:    asm_d[31:24] = byte_data;
      2'd1:    asm_d[23:16] = byte_data;
      2'd2:    asm_d[15:8]  = byte_data;
      default: asm_d[7:0]   = byte_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      remaining_q  <= '0;
      addr_q       <= '0;
      hold_cnt_q   <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_nrst_q   <= 1'b0;
      cpu_nclear_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RUN: begin
          if (start) begin
            cpu_nrst_q   <= 1'b0;
            cpu_nclear_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            addr_q       <= '0;
            byte_cnt_q   <= '0;
            remaining_q  <= n_d;
            if (n_d != '0) begin
              state_q      <= S_COLLECT;
              byte_ready_q <= 1'b1;
            end else begin
              state_q    <= S_HOLD;
              hold_cnt_q <= HOLD_W'(HOLD_CYC - 1);
            end
          end
        end

        S_COLLECT: begin
          if (byte_valid && byte_ready_q) begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              wr_en_q      <= 1'b1;
              wr_addr_q    <= addr_q;
              wr_data_q    <= asm_d;
            end
          end
        end

        S_WRITE: begin
          addr_q      <= addr_q + ADDR_W'(1);
          remaining_q <= remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= HOLD_W'(HOLD_CYC - 1);
          end else begin
            state_q      <= S_COLLECT;
            byte_ready_q <= 1'b1;
          end
        end

        S_HOLD: begin
          // Release reset and clear on the same edge that enters RUN.
          if (hold_cnt_q == '0) begin
            state_q      <= S_RUN;
            cpu_nrst_q   <= 1'b1;
            cpu_nclear_q <= 1'b1;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign InsWrEN    = wr_en_q;
  assign InsWrAddr  = wr_addr_q;
  assign InsDataIn  = wr_data_q;
  assign cpu_nRST   = cpu_nrst_q;
  assign cpu_nclear = cpu_nclear_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ins_loader.sv
// Self-checking bench for ins_loader: a cycle table for reset/single-word/empty-load flow,
// then hand sequences for gapped streams, clamping, mid-word reset and reload.
module tb_ins_loader;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [5:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        InsWrEN;
  logic [4:0]  InsWrAddr;
  logic [31:0] InsDataIn;
  logic        cpu_nRST;
  logic        cpu_nclear;
  logic        busy;
  logic        done;

  ins_loader #(.ADDR_W(5), .DEPTH(32), .HOLD_CYC(4)) dut (
    .clk(clk), .RST(RST), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .InsWrEN(InsWrEN), .InsWrAddr(InsWrAddr), .InsDataIn(InsDataIn),
    .cpu_nRST(cpu_nRST), .cpu_nclear(cpu_nclear), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [4:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(negedge clk) begin
    if (InsWrEN === 1'b1) begin
      wr_addr.push_back(InsWrAddr);
      wr_data.push_back(InsDataIn);
      wr_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic        rst;
    logic        st;
    logic [5:0]  wc;
    logic        bv;
    logic [7:0]  bd;
    logic [42:0] exp;
    string       name;
  } vec_t;

  vec_t tv[$];

  function automatic logic [42:0] mk(input logic br, input logic wen, input logic [4:0] a,
                                     input logic [31:0] d, input logic nr, input logic nc,
                                     input logic bz, input logic dn);
    return {br, wen, a, d, nr, nc, bz, dn};
  endfunction

  function automatic logic [42:0] outs();
    return {byte_ready, InsWrEN, InsWrAddr, InsDataIn, cpu_nRST, cpu_nclear, busy, done};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic do_start(input logic [5:0] n);
    start = 1'b1;
    word_count = n;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    word_count = 6'd0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (byte_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte_ready %b required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_done();
    int g = 0;
    while (done !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("wait_done", {63'd0, done}, 64'd1);
  endtask

  function automatic logic [31:0] clamp_word(input int w);
    logic [7:0] b;
    b = 8'(w);
    return {b, ~b, 8'h5A, b ^ 8'h3C};
  endfunction

  localparam logic [31:0] D1 = 32'h2008_0005;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; start = 1'b0; word_count = 6'd0; byte_valid = 1'b0; byte_data = 8'h00;

    //          rst   st    wc     bv    bd      br wen addr  data  nr ncl bsy dn
    tv.push_back('{1'b1, 1'b1, 6'd5,  1'b1, 8'hFF, mk(0, 0, 5'd0, 32'd0, 0, 0, 0, 0), "reset_0"});
    tv.push_back('{1'b1, 1'b1, 6'd5,  1'b1, 8'hFF, mk(0, 0, 5'd0, 32'd0, 0, 0, 0, 0), "reset_1"});
    tv.push_back('{1'b0, 1'b1, 6'd1,  1'b0, 8'h00, mk(1, 0, 5'd0, 32'd0, 0, 0, 1, 0), "start_1"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b1, 8'h20, mk(1, 0, 5'd0, 32'd0, 0, 0, 1, 0), "byte0"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b1, 8'h08, mk(1, 0, 5'd0, 32'd0, 0, 0, 1, 0), "byte1"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b1, 8'h00, mk(1, 0, 5'd0, 32'd0, 0, 0, 1, 0), "byte2"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b1, 8'h05, mk(0, 1, 5'd0, D1,    0, 0, 1, 0), "write"});
    tv.push_back('{1'b0, 1'b1, 6'd3,  1'b1, 8'hEE, mk(0, 0, 5'd0, D1,    0, 0, 1, 0), "hold_1"});
    tv.push_back('{1'b0, 1'b1, 6'd3,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    0, 0, 1, 0), "hold_2"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    0, 0, 1, 0), "hold_3"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    0, 0, 1, 0), "hold_4"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    1, 1, 0, 1), "run"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b1, 8'h12, mk(0, 0, 5'd0, D1,    1, 1, 0, 1), "run_stay"});
    tv.push_back('{1'b0, 1'b1, 6'd0,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    0, 0, 1, 0), "empty_hold_1"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    0, 0, 1, 0), "empty_hold_2"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    0, 0, 1, 0), "empty_hold_3"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    0, 0, 1, 0), "empty_hold_4"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b0, 8'h00, mk(0, 0, 5'd0, D1,    1, 1, 0, 1), "empty_run"});
    tv.push_back('{1'b0, 1'b1, 6'd63, 1'b0, 8'h00, mk(1, 0, 5'd0, D1,    0, 0, 1, 0), "reload_63"});
    tv.push_back('{1'b1, 1'b1, 6'd1,  1'b1, 8'h55, mk(0, 0, 5'd0, 32'd0, 0, 0, 0, 0), "rst_prio"});
    tv.push_back('{1'b0, 1'b0, 6'd0,  1'b1, 8'h55, mk(0, 0, 5'd0, 32'd0, 0, 0, 0, 0), "idle_after_rst"});

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      RST = tv[i].rst; start = tv[i].st; word_count = tv[i].wc;
      byte_valid = tv[i].bv; byte_data = tv[i].bd;
      @(posedge clk);
      #1;
      chk(tv[i].name, {21'd0, outs()}, {21'd0, tv[i].exp});
      @(negedge clk);
    end
    RST = 1'b0; start = 1'b0; byte_valid = 1'b0;
    chk("table_write_count", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) chk("table_write", {27'd0, wr_addr[0], wr_data[0]}, {27'd0, 5'd0, D1});

    // Gapped stream, two words
    clear_writes();
    do_start(6'd2);
    send_word(32'h8C01_0004, 1);
    send_word(32'hAC02_0008, 1);
    wait_done();
    chk("gap_write_count", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      chk("gap_w0", {27'd0, wr_addr[0], wr_data[0]}, {27'd0, 5'd0, 32'h8C01_0004});
      chk("gap_w1", {27'd0, wr_addr[1], wr_data[1]}, {27'd0, 5'd1, 32'hAC02_0008});
    end

    // Clamp: 40 requested, 32 written, continuous stream
    clear_writes();
    do_start(6'd40);
    for (int w = 0; w < 32; w++) send_word(clamp_word(w), 0);
    byte_valid = 1'b1;
    byte_data = 8'h77;
    for (int k = 0; k < 3; k++) begin
      chk("clamp_no_ready", {63'd0, byte_ready}, 64'd0);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    wait_done();
    chk("clamp_write_count", 64'(wr_addr.size()), 64'd32);
    if (wr_addr.size() == 32) begin
      for (int w = 0; w < 32; w++) begin
        chk($sformatf("clamp_w%0d", w), {27'd0, wr_addr[w], wr_data[w]},
            {27'd0, 5'(w), clamp_word(w)});
      end
      chk("clamp_throughput", 64'(wr_cyc[31] - wr_cyc[0]), 64'd155);
    end

    // Reset mid-word
    clear_writes();
    do_start(6'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    chk("midword_reset", {21'd0, outs()}, {21'd0, mk(0, 0, 5'd0, 32'd0, 0, 0, 0, 0)});
    do_start(6'd1);
    send_word(32'h1122_3344, 0);
    wait_done();
    chk("midword_write_count", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1)
      chk("midword_w0", {27'd0, wr_addr[0], wr_data[0]}, {27'd0, 5'd0, 32'h1122_3344});

    // Reload from RUN with an ignored start during COLLECT
    clear_writes();
    do_start(6'd2);
    chk("reload_enter", {60'd0, cpu_nRST, cpu_nclear, done, busy}, 64'b0001);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    start = 1'b1;
    word_count = 6'd5;
    @(negedge clk);
    start = 1'b0;
    word_count = 6'd0;
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    send_word(32'h0102_0304, 0);
    wait_done();
    chk("reload_write_count", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      chk("reload_w0", {27'd0, wr_addr[0], wr_data[0]}, {27'd0, 5'd0, 32'hDEAD_BEEF});
      chk("reload_w1", {27'd0, wr_addr[1], wr_data[1]}, {27'd0, 5'd1, 32'h0102_0304});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
